idx_bitmap_alloc: RTL

IDX_BITMAP_ALLOC -- requirements
Module: idx_bitmap_alloc

---
 rtl/idx_bitmap_alloc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/idx_bitmap_alloc.sv
// Slot allocator: tracks NUM_ENTRIES slots in a bitmap and grants the lowest free one.
// Latency: grant and index are combinational in the request cycle; state updates at the next edge.
// Backpressure: alloc_gnt_o stays low while full or flushing; the requester holds alloc_req_i until granted.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    release every slot at the next edge
//   alloc_req_i / alloc_gnt_o  allocation handshake; alloc_idx_o is the slot granted
//   free_valid_i / free_idx_i  release one slot; free_err_o flags an illegal release one cycle later
//   used_o, count_o            registered occupancy bitmap and population count
//   full_o, empty_o            derived from the registered count

package cf_math_pkg;
  // Index width for n entries, never narrower than one bit.
  function automatic integer idx_width(input integer n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

module idx_bitmap_alloc #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_WIDTH   = cf_math_pkg::idx_width(NUM_ENTRIES),
  parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   alloc_req_i,
  output logic                   alloc_gnt_o,
  output logic [IDX_WIDTH-1:0]   alloc_idx_o,
  input  logic                   free_valid_i,
  input  logic [IDX_WIDTH-1:0]   free_idx_i,
  output logic                   free_err_o,
  output logic [NUM_ENTRIES-1:0] used_o,
  output logic [CNT_WIDTH-1:0]   count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  logic [NUM_ENTRIES-1:0] used_q, used_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   free_err_q, free_err_d;

  logic [IDX_WIDTH-1:0]   low_idx;
  logic [NUM_ENTRIES-1:0] alloc_mask;
  logic [NUM_ENTRIES-1:0] free_mask;
  logic                   free_hit;
  logic                   free_legal;
  logic                   full;
  logic                   gnt;

  assign full = (cnt_q == CNT_WIDTH'(NUM_ENTRIES));
  assign gnt  = alloc_req_i & ~full & ~flush_i;

  // Lowest-free priority encode; scanning downward leaves the lowest zero last.
  // With no zero present the default of 0 survives, which is the full-case value.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!used_q[i]) low_idx = IDX_WIDTH'(i);
    end
  end

  // Decode both indices into one-hot masks. Decoding the free index this way
  // also makes an out-of-range index simply match nothing.
  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    free_hit   = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (low_idx == IDX_WIDTH'(i)) alloc_mask[i] = gnt;
      if (free_idx_i == IDX_WIDTH'(i)) begin
        free_mask[i] = 1'b1;
        free_hit     = used_q[i];
      end
    end
  end

  assign free_legal = free_valid_i & free_hit;

  // The grant targets a free slot and a legal free targets a used one, so the
  // two masks never overlap and can be applied together.
  always_comb begin
    used_d     = used_q;
    cnt_d      = cnt_q;
    free_err_d = 1'b0;
    if (flush_i) begin
      used_d = '0;
      cnt_d  = '0;
    end else begin
      used_d = used_q | alloc_mask;
      if (free_legal) used_d = used_d & ~free_mask;
      case ({gnt, free_legal})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
      free_err_d = free_valid_i & ~free_legal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      used_q     <= '0;
      cnt_q      <= '0;
      free_err_q <= 1'b0;
    end else begin
      used_q     <= used_d;
      cnt_q      <= cnt_d;
      free_err_q <= free_err_d;
    end
  end

  assign alloc_gnt_o = gnt;
  assign alloc_idx_o = low_idx;
  assign free_err_o  = free_err_q;
  assign used_o      = used_q;
  assign count_o     = cnt_q;
  assign full_o      = full;
  assign empty_o     = (cnt_q == '0);

endmodule
